aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Iterative AES-128 encrypt sequencer. Accepts one plaintext block and applies the initial AddRoundKey (round key 0) itself.
- Then drives the shared single-round datapath NR times: SubBytes, ShiftRows, MixColumns, AddRoundKey, each a registered valid_in/valid_out stage.
- Supplies the round index to the key store and signals the final round, in which the datapath bypasses MixColumns.
- Presents the ciphertext on a valid/ready output. One block in flight.

Parameters:
- DATA_WIDTH, 128, block and round-key width.
- NR, 10, number of rounds after round 0.
- TIMEOUT, 64, max cycles in WAIT for datapath return before error; >= DP latency + 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  controller can accept a block.
- in_data  in  DATA_WIDTH  plaintext.
- rk_idx  out  4  round-key index to key store.
- rk_data  in  DATA_WIDTH  round key for rk_idx, combinational from key store.
- dp_valid_out  out  1  one-cycle launch pulse into datapath.
- dp_data_out  out  DATA_WIDTH  state launched into datapath.
- dp_last_round  out  1  high while the launched round is round NR (MixColumns bypass).
- dp_valid_in  in  1  datapath result valid.
- dp_data_in  in  DATA_WIDTH  datapath result.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  DATA_WIDTH  ciphertext.
- busy  out  1  high in any state except IDLE.
- err_spurious  out  1  sticky: dp_valid_in seen outside WAIT.
- err_timeout  out  1  sticky: WAIT exceeded TIMEOUT.
- err_clr  in  1  synchronous clear of both error flags.

Behaviour:
- Reset (rst low, async): FSM=IDLE, round=0, state register=0, wait counter=0. All outputs 0 except in_ready=1; rk_idx=0.
- FSM states: IDLE, ISSUE, WAIT, DONE. Encoded 2 bits.
- IDLE:
  - in_ready=1, rk_idx=0.
  - on in_valid: state <= in_data ^ rk_data; round <= 1; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - dp_valid_out=1, dp_data_out=state, rk_idx=round, dp_last_round=(round==NR).
  - Go to WAIT; clear wait counter.
- WAIT:
  - rk_idx=round and dp_last_round held stable, since the AddRoundKey stage reads them. dp_valid_out=0.
  - On dp_valid_in: state <= dp_data_in. If round==NR go to DONE, else round <= round+1 and go to ISSUE.
  - Else wait counter +1. On reaching TIMEOUT: set err_timeout, drop state, go to IDLE.
- DONE:
  - out_valid=1, out_data=state; out_data stable while out_valid && !out_ready.
  - On out_ready go to IDLE; in_ready rises next cycle, no same-cycle re-accept.
- dp_data_out is 0 outside ISSUE; out_data is 0 outside DONE.
- Latency, nominal 4-stage datapath: round period = DP latency + 1 = 5 cycles. out_valid rises NR*5 = 50 rising edges after the accepting edge.
- The controller is latency-agnostic: it waits for dp_valid_in, never counts.
- dp_valid_in when not in WAIT: set err_spurious, data ignored, FSM unaffected.
- dp_valid_in in the same cycle as the timeout threshold: dp_valid_in wins, no error.
- err_clr and a new error event in the same cycle: the set wins.
- Error flags never block operation.
- in_valid is ignored outside IDLE (in_ready=0).
- Reset asserted mid-block: immediate abort to reset values; the datapath's own reset flushes in-flight data.

Decomposition:
- Shared package aes_pkg:
  - DATA_WIDTH, NR, round-index width.
  - FSM state localparams IDLE/ISSUE/WAIT/DONE, shared with a future decrypt controller.
- Sub-module aes_wait_timer: wait counter with clear, enable and terminal-count flag. Reused by key-expansion control.

Test Plan:
- FIPS-197 C.1, bench with the real round datapath and key store:
  - stimulus: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - response: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 50 edges after accept.
  - check: rk_idx sequence 0,1..10; dp_last_round high only on the 10th launch.
- Backpressure: hold out_ready=0 for 20 cycles. Out_valid and out_data stay stable and in_ready=0. Release: IDLE next cycle, second block accepted and correct.
- Spurious: pulse dp_valid_in while IDLE. err_spurious=1, busy stays 0. err_clr clears it. A following block encrypts correctly.
- Timeout: stub datapath never returns. After TIMEOUT=64 WAIT cycles, err_timeout=1, busy=0, in_ready=1, out_valid never asserted.
- Reset mid-round: assert rst in round 5 WAIT. All outputs go to reset values asynchronously. After release, FIPS vector passes.
- Back-to-back and flow control:
  - in_valid held high continuously: exactly one block accepted per transaction, in_ready low while busy.
  - datapath stub with 7-cycle latency: round period 8, out_valid after 80 edges, same ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block constants and controller state encodings
package aes_pkg;
    localparam int DATA_WIDTH = 128;
    localparam int NR         = 10;
    localparam int RIDX_W     = 4;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/aes_wait_timer.sv
// aes_wait_timer: cycle counter with clear, enable and terminal-count flag at LIMIT-1
module aes_wait_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc_o = cnt_q == W'(LIMIT - 1);
    always_comb cnt_d = clr_i ? '0 : (en_i && !tc_o) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encrypt sequencer driving a shared single-round datapath
module aes_round_ctrl #(
    parameter int DATA_WIDTH = aes_pkg::DATA_WIDTH,
    parameter int NR         = aes_pkg::NR,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [3:0]            rk_idx,
    input  logic [DATA_WIDTH-1:0] rk_data,
    output logic                  dp_valid_out,
    output logic [DATA_WIDTH-1:0] dp_data_out,
    output logic                  dp_last_round,
    input  logic                  dp_valid_in,
    input  logic [DATA_WIDTH-1:0] dp_data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  err_spurious,
    output logic                  err_timeout,
    input  logic                  err_clr
);
    import aes_pkg::*;

    logic [1:0]            st_q, st_d;
    logic [RIDX_W-1:0]     rnd_q, rnd_d;
    logic [DATA_WIDTH-1:0] blk_q, blk_d;
    logic                  err_sp_q, err_sp_d, err_to_q, err_to_d;
    logic                  tc, last, timeout;

    assign last    = rnd_q == RIDX_W'(NR);
    assign timeout = st_q == WAIT && !dp_valid_in && tc;

    aes_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (st_q != WAIT),
        .en_i  (st_q == WAIT && !dp_valid_in),
        .tc_o  (tc)
    );

    always_comb begin
        st_d  = st_q;
        rnd_d = rnd_q;
        blk_d = blk_q;
        case (st_q)
            IDLE: if (in_valid) begin
                blk_d = in_data ^ rk_data;
                rnd_d = RIDX_W'(1);
                st_d  = ISSUE;
            end
            ISSUE: st_d = WAIT;
            WAIT: if (dp_valid_in) begin
                blk_d = dp_data_in;
                rnd_d = last ? rnd_q : rnd_q + RIDX_W'(1);
                st_d  = last ? DONE : ISSUE;
            end else if (tc) begin
                blk_d = '0;
                rnd_d = '0;
                st_d  = IDLE;
            end
            default: st_d = out_ready ? IDLE : DONE;
        endcase
    end

    // a new error event beats a simultaneous clear
    assign err_sp_d = (dp_valid_in && st_q != WAIT) || (err_sp_q && !err_clr);
    assign err_to_d = timeout || (err_to_q && !err_clr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= IDLE;
            rnd_q    <= '0;
            blk_q    <= '0;
            err_sp_q <= 1'b0;
            err_to_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            rnd_q    <= rnd_d;
            blk_q    <= blk_d;
            err_sp_q <= err_sp_d;
            err_to_q <= err_to_d;
        end
    end

    assign in_ready      = st_q == IDLE;
    assign busy          = st_q != IDLE;
    assign rk_idx        = in_ready ? '0 : rnd_q;
    assign dp_valid_out  = st_q == ISSUE;
    assign dp_data_out   = dp_valid_out ? blk_q : '0;
    assign dp_last_round = (st_q == ISSUE || st_q == WAIT) && last;
    assign out_valid     = st_q == DONE;
    assign out_data      = out_valid ? blk_q : '0;
    assign err_spurious  = err_sp_q;
    assign err_timeout   = err_to_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench with a behavioural AES round datapath and key store
module tb_aes_round_ctrl;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0, rst = 1'b0;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [127:0] in_data = '0, rk_data, dp_data_out, dp_data_in, out_data;
    logic [3:0]   rk_idx;
    logic         dp_valid_out, dp_last_round, dp_valid_in, busy;
    logic         err_spurious, err_timeout, err_clr = 1'b0;

    aes_round_ctrl #(.DATA_WIDTH(128), .NR(10), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_idx(rk_idx), .rk_data(rk_data), .dp_valid_out(dp_valid_out), .dp_data_out(dp_data_out),
        .dp_last_round(dp_last_round), .dp_valid_in(dp_valid_in), .dp_data_in(dp_data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .err_spurious(err_spurious), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, acc_cyc = 0, launches = 0, accepts = 0, pops = 0;
    int lat = 4;
    logic dead = 1'b0, inj = 1'b0, ov_prev = 1'b0;

    typedef struct { logic [127:0] ct; int lat; } exp_t;
    exp_t sb [$];

    logic [7:0]   sbox [256];
    logic [127:0] rk [16];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sb_calc(input logic [7:0] v);
        logic [7:0] inv, s, c;
        inv = 8'd1;
        c   = 8'h63;
        for (int k = 0; k < 254; k++) inv = gm(inv, v);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   x [4];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        for (int i = 0; i < 16; i++) b[i] = a[(i + 4*(i%4)) % 16];
        if (!fin)
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) x[j] = b[4*c+j];
                for (int j = 0; j < 4; j++)
                    b[4*c+j] = xt(x[j]) ^ xt(x[(j+1)%4]) ^ x[(j+1)%4] ^ x[(j+2)%4] ^ x[(j+3)%4];
            end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = r < 11 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    assign rk_data = rk[rk_idx];

    // round datapath stub: 'lat' registered stages, AddRoundKey/last-round sampled at the final stage
    logic [7:0]   vq;
    logic [127:0] dq [8];
    logic         dpv_q;
    logic [127:0] dpd_q;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            vq    <= '0;
            dpv_q <= 1'b0;
            dpd_q <= '0;
        end else begin
            vq    <= {vq[6:0], dp_valid_out};
            dq[0] <= dp_data_out;
            for (int i = 1; i < 8; i++) dq[i] <= dq[i-1];
            dpv_q <= vq[lat-2] && !dead;
            if (vq[lat-2]) dpd_q <= aes_round(dq[lat-2], rk_data, dp_last_round);
        end
    end
    assign dp_valid_in = dpv_q | inj;
    assign dp_data_in  = dpd_q;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ctl"}, 128'({in_ready, busy, dp_valid_out, dp_last_round, out_valid,
                                err_spurious, err_timeout, rk_idx}), 128'h400);
        chk({nm, "_dpd"}, dp_data_out, '0);
        chk({nm, "_out"}, out_data, '0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] ct, input bit expect_out);
        int n;
        n = 0;
        while (!in_ready && n < 300) begin tick(1); n++; end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send: in_ready low for %0d cycles", n);
        end
        if (expect_out) sb.push_back('{ct, 10 * (lat + 1)});
        in_valid = 1'b1;
        in_data  = pt;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 3000) begin tick(1); n++; end
        if (n >= 3000) begin
            tests++; fails++;
            $display("FAIL drain: %0d blocks outstanding after %0d cycles", sb.size(), n);
            sb.delete();
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready) begin
                acc_cyc  = cyc + 1;
                launches = 0;
                accepts++;
                chk("rk_idx_accept", 128'(rk_idx), '0);
            end
            if (dp_valid_out) begin
                launches++;
                chk("rk_idx_launch", 128'(rk_idx), 128'(launches));
                chk("last_round", 128'(dp_last_round), 128'(launches == 10));
            end
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out: out_valid=1 with no block pending, out_data %h", out_data);
                end else chk("latency", 128'(cyc - acc_cyc), 128'(sb[0].lat));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                pops++;
                chk("out_data", out_data, e.ct);
            end
            ov_prev = out_valid;
        end else ov_prev = 1'b0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int v = 0; v < 256; v++) sbox[v] = sb_calc(8'(v));
        expand(KC);
        tick(3);
        chk_reset("reset");
        rst = 1'b1;
        tick(2);

        send(PC, CC, 1'b1);
        drain();

        expand('0);
        send('0, CZ, 1'b1);
        drain();

        expand(KB);
        out_ready = 1'b0;
        send(PB, CB, 1'b1);
        n = 0;
        while (!out_valid && n < 300) begin tick(1); n++; end
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 128'(out_valid), 128'd1);
            chk("bp_data", out_data, CB);
            chk("bp_in_ready", 128'(in_ready), '0);
            tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        chk("bp_idle", 128'(in_ready), 128'd1);
        expand(KC);
        send(PC, CC, 1'b1);
        drain();

        inj = 1'b1;
        tick(1);
        inj = 1'b0;
        chk("spur_set", 128'(err_spurious), 128'd1);
        chk("spur_busy", 128'(busy), '0);
        inj = 1'b1;
        err_clr = 1'b1;
        tick(1);
        inj = 1'b0;
        chk("spur_set_wins", 128'(err_spurious), 128'd1);
        tick(1);
        err_clr = 1'b0;
        chk("spur_clr", 128'(err_spurious), '0);
        send(PC, CC, 1'b1);
        drain();

        dead = 1'b1;
        send(PC, CC, 1'b0);
        tick(64);
        chk("tmo_still_busy", 128'({busy, err_timeout}), 128'b10);
        tick(1);
        chk("tmo_flags", 128'({err_timeout, busy, in_ready, out_valid}), 128'b1010);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        dead = 1'b0;
        chk("tmo_clr", 128'(err_timeout), '0);

        send(PC, CC, 1'b1);
        n = 0;
        while (launches < 5 && n < 300) begin @(posedge clk); n++; end
        #3;
        rst = 1'b0;
        #1;
        chk_reset("mid_reset");
        sb.delete();
        tick(2);
        rst = 1'b1;
        tick(1);
        send(PC, CC, 1'b1);
        drain();

        accepts = 0;
        pops = 0;
        sb.push_back('{CC, 50});
        sb.push_back('{CC, 50});
        in_data  = PC;
        in_valid = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; end while (pops < 2 && n < 400);
        #1;
        in_valid = 1'b0;
        drain();
        chk("b2b_accepts", 128'(accepts), 128'd2);

        lat = 7;
        send(PC, CC, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
